// File: rtl/lsu_mem_ctrl.sv
// Load/store unit driving a word-addressed data memory: sub-word RMW stores, extended loads.
// Optional macro LSU_BOUNDS_CHECK_EN rejects aligned requests at or beyond MEM_WORDS.
module lsu_mem_ctrl #(
  parameter int MEM_WORDS   = 32,
  parameter int RD_WAIT_MAX = 4
) (
  input  logic        clk,
  input  logic        ip_rst_n,
  input  logic        ip_req_valid,
  output logic        op_req_ready,
  input  logic        ip_req_we,
  input  logic [1:0]  ip_req_size,
  input  logic        ip_req_unsigned,
  input  logic [31:0] ip_req_addr,
  input  logic [31:0] ip_req_wdata,
  output logic        op_resp_valid,
  input  logic        ip_resp_ready,
  output logic [31:0] op_resp_rdata,
  output logic        op_resp_err,
  output logic        op_mem_read,
  output logic        op_mem_write,
  output logic [31:0] op_mem_addr,
  output logic [31:0] op_mem_data,
  input  logic [31:0] ip_mem_out,
  input  logic        ip_mem_data_valid
);

  // state | meaning
  // IDLE  | ready; latch request, route by alignment/kind
  // RD    | memory read (load or sub-word store), bounded by RD_WAIT_MAX
  // WR    | single-cycle write of the merged word
  // RESP  | response held until consumed
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  if (RD_WAIT_MAX < 1 || RD_WAIT_MAX > 15) begin : g_bad_wait
    $error("lsu_mem_ctrl: RD_WAIT_MAX must be 1..15");
  end
  if (MEM_WORDS < 1) begin : g_bad_depth
    $error("lsu_mem_ctrl: MEM_WORDS must be positive");
  end

  localparam logic [3:0] WAIT_INIT = 4'(RD_WAIT_MAX);

  state_t      state_q, state_d;
  logic        req_we_q, req_we_d;
  logic [1:0]  req_size_q, req_size_d;
  logic        req_uns_q, req_uns_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  logic        misalign;
  logic        oob;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;
  logic [31:0] merged;

  always_comb begin
    misalign = (ip_req_size == 2'b11) ||
               (ip_req_size == 2'b01 && ip_req_addr[0]) ||
               (ip_req_size == 2'b10 && ip_req_addr[1:0] != 2'b00);
  end

`ifdef LSU_BOUNDS_CHECK_EN
  always_comb begin
    oob = ({2'b00, ip_req_addr[31:2]} >= 32'(MEM_WORDS));
  end
`else
  always_comb begin
    oob = 1'b0;
  end
`endif

  assign op_req_ready = (state_q == S_IDLE) && ip_rst_n;

  always_comb begin
    state_d     = state_q;
    req_we_d    = req_we_q;
    req_size_d  = req_size_q;
    req_uns_d   = req_uns_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    rbuf_d      = rbuf_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (ip_req_valid && op_req_ready) begin
          req_we_d    = ip_req_we;
          req_size_d  = ip_req_size;
          req_uns_d   = ip_req_unsigned;
          req_addr_d  = ip_req_addr;
          req_wdata_d = ip_req_wdata;
          cnt_d       = WAIT_INIT;
          err_d       = 1'b0;
          if (misalign || oob) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (ip_req_we && ip_req_size == 2'b10) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        // Valid data wins over the timeout on the final allowed cycle.
        if (ip_mem_data_valid) begin
          rbuf_d  = ip_mem_out;
          state_d = req_we_q ? S_WR : S_RESP;
        end else if (cnt_q <= 4'd1) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WR: state_d = S_RESP;
      S_RESP: begin
        if (ip_resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge ip_rst_n) begin
    if (!ip_rst_n) begin
      state_q     <= S_IDLE;
      req_we_q    <= 1'b0;
      req_size_q  <= 2'b00;
      req_uns_q   <= 1'b0;
      req_addr_q  <= 32'h0;
      req_wdata_q <= 32'h0;
      rbuf_q      <= 32'h0;
      cnt_q       <= 4'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_we_q    <= req_we_d;
      req_size_q  <= req_size_d;
      req_uns_q   <= req_uns_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      rbuf_q      <= rbuf_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    lane_byte = rbuf_q[7:0];
    case (req_addr_q[1:0])
      2'd1:    lane_byte = rbuf_q[15:8];
      2'd2:    lane_byte = rbuf_q[23:16];
      2'd3:    lane_byte = rbuf_q[31:24];
      default: lane_byte = rbuf_q[7:0];
    endcase
    lane_half = req_addr_q[1] ? rbuf_q[31:16] : rbuf_q[15:0];
  end

  always_comb begin
    load_data = rbuf_q;
    case (req_size_q)
      2'b00: load_data = req_uns_q ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      2'b01: load_data = req_uns_q ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
      default: load_data = rbuf_q;
    endcase
  end

  always_comb begin
    merged = req_wdata_q;
    case (req_size_q)
      2'b00: begin
        case (req_addr_q[1:0])
          2'd0:    merged = {rbuf_q[31:8], req_wdata_q[7:0]};
          2'd1:    merged = {rbuf_q[31:16], req_wdata_q[7:0], rbuf_q[7:0]};
          2'd2:    merged = {rbuf_q[31:24], req_wdata_q[7:0], rbuf_q[15:0]};
          default: merged = {req_wdata_q[7:0], rbuf_q[23:0]};
        endcase
      end
      2'b01: merged = req_addr_q[1] ? {req_wdata_q[15:0], rbuf_q[15:0]}
                                    : {rbuf_q[31:16], req_wdata_q[15:0]};
      default: merged = req_wdata_q;
    endcase
  end

  assign op_resp_valid = (state_q == S_RESP);
  assign op_resp_err   = (state_q == S_RESP) && err_q;
  assign op_resp_rdata = (state_q == S_RESP && !req_we_q && !err_q) ? load_data : 32'h0;
  assign op_mem_read   = (state_q == S_RD);
  assign op_mem_write  = (state_q == S_WR);
  assign op_mem_addr   = {req_addr_q[31:2], 2'b00};
  assign op_mem_data   = merged;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: vector table plus handshake, timeout and reset sequences.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        ip_rst_n;
  logic        ip_req_valid;
  logic        op_req_ready;
  logic        ip_req_we;
  logic [1:0]  ip_req_size;
  logic        ip_req_unsigned;
  logic [31:0] ip_req_addr;
  logic [31:0] ip_req_wdata;
  logic        op_resp_valid;
  logic        ip_resp_ready;
  logic [31:0] op_resp_rdata;
  logic        op_resp_err;
  logic        op_mem_read;
  logic        op_mem_write;
  logic [31:0] op_mem_addr;
  logic [31:0] op_mem_data;
  logic [31:0] ip_mem_out;
  logic        ip_mem_data_valid;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.MEM_WORDS(32), .RD_WAIT_MAX(4)) dut (
    .clk              (clk),
    .ip_rst_n         (ip_rst_n),
    .ip_req_valid     (ip_req_valid),
    .op_req_ready     (op_req_ready),
    .ip_req_we        (ip_req_we),
    .ip_req_size      (ip_req_size),
    .ip_req_unsigned  (ip_req_unsigned),
    .ip_req_addr      (ip_req_addr),
    .ip_req_wdata     (ip_req_wdata),
    .op_resp_valid    (op_resp_valid),
    .ip_resp_ready    (ip_resp_ready),
    .op_resp_rdata    (op_resp_rdata),
    .op_resp_err      (op_resp_err),
    .op_mem_read      (op_mem_read),
    .op_mem_write     (op_mem_write),
    .op_mem_addr      (op_mem_addr),
    .op_mem_data      (op_mem_data),
    .ip_mem_out       (ip_mem_out),
    .ip_mem_data_valid(ip_mem_data_valid)
  );

  // Memory model: combinational read, write staged at negedge and committed on the next posedge.
  logic [31:0] mem [0:31];
  logic        mem_load;
  logic        mem_valid_en;
  logic        wr_pend;
  logic [4:0]  wr_idx;
  logic [31:0] wr_word;
  int          rd_cycles, wr_cycles, both_cycles;

  assign ip_mem_out        = mem[op_mem_addr[6:2]];
  assign ip_mem_data_valid = mem_valid_en;

  always @(negedge clk) begin
    wr_pend = op_mem_write;
    wr_idx  = op_mem_addr[6:2];
    wr_word = op_mem_data;
    if (op_mem_read) rd_cycles++;
    if (op_mem_write) wr_cycles++;
    if (op_mem_read && op_mem_write) both_cycles++;
  end

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
      mem[4] <= 32'h80F1_7F02;
    end else if (wr_pend && ip_rst_n) begin
      mem[wr_idx] <= wr_word;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    int          mem_idx;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input int exp_lat, input int exp_rd, input int exp_wr,
                              input int mem_idx, input logic [31:0] exp_mem);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    v.exp_rd = exp_rd; v.exp_wr = exp_wr; v.mem_idx = mem_idx; v.exp_mem = exp_mem;
    return v;
  endfunction

  // Called #1 after a posedge with the DUT idle; returns #1 after a posedge.
  task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input bit consume,
                         output int lat, output logic [31:0] rdata, output logic err);
    ip_req_valid    = 1'b1;
    ip_req_we       = we;
    ip_req_size     = sz;
    ip_req_unsigned = uns;
    ip_req_addr     = a;
    ip_req_wdata    = wd;
    @(posedge clk); #1;
    ip_req_valid = 1'b0;
    lat = 1;
    while (!op_resp_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = op_resp_rdata;
    err   = op_resp_err;
    if (consume) begin
      ip_resp_ready = 1'b1;
      @(posedge clk); #1;
      ip_resp_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, rd0, wr0;
    logic [31:0] rdata;
    logic        err;

    ip_rst_n = 1'b1;
    ip_req_valid = 1'b0; ip_req_we = 1'b0; ip_req_size = 2'b00; ip_req_unsigned = 1'b0;
    ip_req_addr = 32'h0; ip_req_wdata = 32'h0; ip_resp_ready = 1'b0;
    mem_load = 1'b1; mem_valid_en = 1'b1;
    rd_cycles = 0; wr_cycles = 0; both_cycles = 0;
    #1 ip_rst_n = 1'b0;
    #1;
    chk("rst ready", {31'h0, op_req_ready}, 32'h0);
    chk("rst resp_valid", {31'h0, op_resp_valid}, 32'h0);
    chk("rst mem_rw", {30'h0, op_mem_read, op_mem_write}, 32'h0);
    chk("rst rdata", op_resp_rdata, 32'h0);
    chk("rst mem_addr", op_mem_addr, 32'h0);
    chk("rst mem_data", op_mem_data, 32'h0);
    repeat (3) @(posedge clk);
    #3 ip_rst_n = 1'b1;
    @(posedge clk); #1;
    mem_load = 1'b0;
    chk("post-rst ready", {31'h0, op_req_ready}, 32'h1);

    vq.push_back(mk(1, 2'b10, 0, 32'h08, 32'hDEADBEEF, 32'h0,        0, 2, 0, 1, 2, 32'hDEADBEEF));
    vq.push_back(mk(0, 2'b10, 0, 32'h08, 32'h0,        32'hDEADBEEF, 0, 2, 1, 0, -1, 32'h0));
    vq.push_back(mk(1, 2'b00, 0, 32'h0A, 32'hAAAAAA55, 32'h0,        0, 3, 1, 1, 2, 32'hDE55BEEF));
    vq.push_back(mk(0, 2'b00, 0, 32'h11, 32'h0,        32'h0000007F, 0, 2, 1, 0, -1, 32'h0));
    vq.push_back(mk(0, 2'b01, 0, 32'h12, 32'h0,        32'hFFFF80F1, 0, 2, 1, 0, -1, 32'h0));
    vq.push_back(mk(0, 2'b01, 1, 32'h12, 32'h0,        32'h000080F1, 0, 2, 1, 0, -1, 32'h0));
    vq.push_back(mk(0, 2'b01, 0, 32'h13, 32'h0,        32'h0,        1, 1, 0, 0, -1, 32'h0));
    vq.push_back(mk(1, 2'b10, 0, 32'h06, 32'h12345678, 32'h0,        1, 1, 0, 0, 1, 32'h0));
    vq.push_back(mk(0, 2'b11, 0, 32'h00, 32'h0,        32'h0,        1, 1, 0, 0, -1, 32'h0));
    vq.push_back(mk(1, 2'b01, 0, 32'h01, 32'h0000FFFF, 32'h0,        1, 1, 0, 0, 0, 32'h0));
    vq.push_back(mk(1, 2'b01, 0, 32'h12, 32'hFFFFABCD, 32'h0,        0, 3, 1, 1, 4, 32'hABCD7F02));
    vq.push_back(mk(0, 2'b00, 0, 32'h13, 32'h0,        32'hFFFFFFAB, 0, 2, 1, 0, -1, 32'h0));
    vq.push_back(mk(0, 2'b00, 1, 32'h10, 32'h0,        32'h00000002, 0, 2, 1, 0, -1, 32'h0));
    vq.push_back(mk(1, 2'b00, 0, 32'h0C, 32'h000000C3, 32'h0,        0, 3, 1, 1, 3, 32'h000000C3));
    vq.push_back(mk(0, 2'b01, 0, 32'h10, 32'h0,        32'h00007F02, 0, 2, 1, 0, -1, 32'h0));
    vq.push_back(mk(0, 2'b00, 1, 32'h0B, 32'h0,        32'h000000DE, 0, 2, 1, 0, -1, 32'h0));
    vq.push_back(mk(1, 2'b00, 0, 32'h0F, 32'h00000011, 32'h0,        0, 3, 1, 1, 3, 32'h110000C3));
    vq.push_back(mk(0, 2'b10, 1, 32'h0C, 32'h0,        32'h110000C3, 0, 2, 1, 0, -1, 32'h0));
    vq.push_back(mk(1, 2'b01, 0, 32'h0E, 32'h0000BEEF, 32'h0,        0, 3, 1, 1, 3, 32'hBEEF00C3));
`ifdef LSU_BOUNDS_CHECK_EN
    vq.push_back(mk(0, 2'b10, 0, 32'h80, 32'h0,        32'h0,        1, 1, 0, 0, -1, 32'h0));
`else
    vq.push_back(mk(0, 2'b10, 0, 32'h80, 32'h0,        32'h0,        0, 2, 1, 0, -1, 32'h0));
`endif

    foreach (vq[i]) begin
      chk($sformatf("v%0d ready", i), {31'h0, op_req_ready}, 32'h1);
      rd0 = rd_cycles; wr0 = wr_cycles;
      run_req(vq[i].we, vq[i].size, vq[i].uns, vq[i].addr, vq[i].wdata, 1'b1, lat, rdata, err);
      chk($sformatf("v%0d rdata", i), rdata, vq[i].exp_rdata);
      chk($sformatf("v%0d err", i), {31'h0, err}, {31'h0, vq[i].exp_err});
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(vq[i].exp_lat));
      chk($sformatf("v%0d rd cycles", i), 32'(rd_cycles - rd0), 32'(vq[i].exp_rd));
      chk($sformatf("v%0d wr cycles", i), 32'(wr_cycles - wr0), 32'(vq[i].exp_wr));
      if (vq[i].mem_idx >= 0)
        chk($sformatf("v%0d mem", i), mem[vq[i].mem_idx], vq[i].exp_mem);
    end

    // Response back-pressure: data held, no new accept.
    run_req(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 1'b0, lat, rdata, err);
    chk("hold latency", 32'(lat), 32'd2);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("hold%0d valid", c), {31'h0, op_resp_valid}, 32'h1);
      chk($sformatf("hold%0d rdata", c), op_resp_rdata, 32'hBEEF00C3);
      chk($sformatf("hold%0d ready", c), {31'h0, op_req_ready}, 32'h0);
      @(posedge clk); #1;
    end
    ip_resp_ready = 1'b1;
    @(posedge clk); #1;
    ip_resp_ready = 1'b0;
    chk("release valid", {31'h0, op_resp_valid}, 32'h0);
    chk("release ready", {31'h0, op_req_ready}, 32'h1);

    // Read timeout: load and sub-word store both end in error without a write.
    mem_valid_en = 1'b0;
    rd0 = rd_cycles; wr0 = wr_cycles;
    run_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b1, lat, rdata, err);
    chk("to-load latency", 32'(lat), 32'd5);
    chk("to-load err", {31'h0, err}, 32'h1);
    chk("to-load rdata", rdata, 32'h0);
    chk("to-load rd cycles", 32'(rd_cycles - rd0), 32'd4);
    rd0 = rd_cycles; wr0 = wr_cycles;
    run_req(1'b1, 2'b00, 1'b0, 32'h08, 32'h000000AA, 1'b1, lat, rdata, err);
    chk("to-store latency", 32'(lat), 32'd5);
    chk("to-store err", {31'h0, err}, 32'h1);
    chk("to-store wr cycles", 32'(wr_cycles - wr0), 32'd0);
    chk("to-store mem", mem[2], 32'hDE55BEEF);
    mem_valid_en = 1'b1;

    // Reset during the write cycle of a byte store.
    wr0 = wr_cycles;
    ip_req_valid = 1'b1; ip_req_we = 1'b1; ip_req_size = 2'b00; ip_req_unsigned = 1'b0;
    ip_req_addr = 32'h0C; ip_req_wdata = 32'h00000077;
    @(posedge clk); #1;
    ip_req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rstwr write high", {31'h0, op_mem_write}, 32'h1);
    #1 ip_rst_n = 1'b0;
    #1;
    chk("rstwr write low", {31'h0, op_mem_write}, 32'h0);
    chk("rstwr ready", {31'h0, op_req_ready}, 32'h0);
    chk("rstwr resp", {30'h0, op_resp_valid, op_resp_err}, 32'h0);
    chk("rstwr mem_addr", op_mem_addr, 32'h0);
    chk("rstwr mem_data", op_mem_data, 32'h0);
    repeat (2) @(posedge clk);
    #3 ip_rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstwr mem kept", mem[3], 32'hBEEF00C3);
    chk("rstwr no write", 32'(wr_cycles - wr0), 32'd0);
    run_req(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 1'b1, lat, rdata, err);
    chk("rstwr reload", rdata, 32'hBEEF00C3);

    chk("never rd+wr", 32'(both_cycles), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit between the execute stage and the word-addressed data memory. It sits directly upstream of the memory and drives its read/write/address/data pins.
- Accepts byte, halfword and word requests over a valid/ready handshake.
- Performs read-modify-write for sub-word stores and sign- or zero-extends loads.
- Checks alignment and returns one response per accepted request.

Parameters:
- MEM_WORDS, 32, depth of the attached data memory in 32-bit words; used only by the optional bounds check.
- RD_WAIT_MAX, 4, maximum cycles spent in RD waiting for ip_mem_data_valid before reporting an error; range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- ip_rst_n  in  1  asynchronous active-low reset.
- ip_req_valid  in  1  request present.
- op_req_ready  out  1  unit can accept a request.
- ip_req_we  in  1  1 = store, 0 = load.
- ip_req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as a misalignment error.
- ip_req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- ip_req_addr  in  32  byte address.
- ip_req_wdata  in  32  store data, right-justified.
- op_resp_valid  out  1  response present.
- ip_resp_ready  in  1  consumer takes the response.
- op_resp_rdata  out  32  extended load data; 0 for stores and errors.
- op_resp_err  out  1  misaligned, timed-out or (optionally) out-of-range access.
- op_mem_read  out  1  memory read enable.
- op_mem_write  out  1  memory write enable; the write commits on the next clk edge.
- op_mem_addr  out  32  word-aligned address: {req_addr[31:2], 2'b00}.
- op_mem_data  out  32  merged write word.
- ip_mem_out  in  32  combinational read data from memory.
- ip_mem_data_valid  in  1  read data valid.

Behaviour:
- Reset (asynchronous, ip_rst_n = 0):
  - state = IDLE; request latch, read buffer and wait counter cleared.
  - op_resp_valid, op_resp_err, op_mem_read, op_mem_write = 0; op_resp_rdata, op_mem_addr, op_mem_data = 0.
  - op_req_ready is forced 0 while reset is asserted.
  - Reset asserted mid-operation abandons the request. No write is issued during reset or on the edge it deasserts.
- FSM states: IDLE, RD, WR, RESP. All memory-side outputs are decoded from the registered state and latched request, not from the ip_req_* inputs.
- IDLE:
  - op_req_ready = 1. A request is accepted on the edge where valid && ready; all request fields are latched.
  - Misaligned request (half with addr[0] = 1; word with addr[1:0] != 0; size 11): go to RESP with err = 1, no memory access.
  - Load -> RD. Word store -> WR. Byte/half store -> RD (read-modify-write).
- RD:
  - op_mem_read = 1; the counter increments each cycle.
  - On an edge with ip_mem_data_valid = 1, capture ip_mem_out into rbuf, then go to RESP (load) or WR (store).
  - If the counter reaches RD_WAIT_MAX without valid: go to RESP with err = 1, no write.
- WR:
  - op_mem_write = 1 for exactly one cycle, then go to RESP.
  - Merge rules:
    - Word: op_mem_data = wdata.
    - Half: wdata[15:0] replaces rbuf[15:0] when addr[1] = 0, else rbuf[31:16].
    - Byte: wdata[7:0] replaces lane addr[1:0] of rbuf; the other lanes are kept.
- RESP:
  - op_resp_valid = 1; rdata and err are held stable until ip_resp_ready = 1, then go to IDLE.
  - A new request cannot be accepted in the same cycle the response is consumed (ready is 0 in RESP).
- Load extraction: select the lane exactly as for the store merge, then extend to 32 bits per ip_req_unsigned.
- Latency from the accept edge to op_resp_valid (memory with valid = 1 immediately):
  - aligned load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - misaligned: 1 cycle
- Exactly one response per accepted request. op_mem_read and op_mem_write are never asserted together.

Optional Feature:
- Macro LSU_BOUNDS_CHECK_EN.
- Defined: in IDLE, an aligned request with addr[31:2] >= MEM_WORDS goes to RESP with err = 1 and no memory access.
- Undefined: no range check; the full address is driven to memory and MEM_WORDS is unused.

Test Plan:
- Word store addr 0x08, data 0xDEADBEEF, then word load 0x08 -> op_mem_write pulses 1 cycle; load response 0xDEADBEEF, err 0, valid 2 cycles after accept.
- After memory word 0x08 = 0xDEADBEEF, byte store 0x0A data 0x55 -> RD then WR; memory word = 0xDE55BEEF; response 3 cycles after accept.
- Memory word 0x10 = 0x80F1_7F02: signed byte load 0x11 -> 0x0000007F; signed half load 0x12 -> 0xFFFF80F1; unsigned half load 0x12 -> 0x000080F1.
- Half load 0x13 and word store 0x06 -> err 1, rdata 0, no op_mem_read/op_mem_write ever asserted, response 1 cycle after accept.
- Hold ip_resp_ready = 0 for 5 cycles -> resp stays valid with stable data, op_req_ready 0; then assert ready -> IDLE next cycle. Assert ip_rst_n = 0 during WR of a byte store -> op_mem_write drops immediately, memory unchanged, all outputs 0.
- Hold ip_mem_data_valid = 0 with RD_WAIT_MAX = 4 -> err response after 4 RD cycles, no write. With LSU_BOUNDS_CHECK_EN defined, load 0x80 -> err 1, no access.
